// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
//   Request/response bundle between a pipelined core's load/store unit and
//   data_mem_ctrl.
//
//   Handshake: the master holds req_valid and all req_* fields stable until a
//   rising edge where req_valid & req_ready are both 1; that edge accepts the
//   request. req_ready never depends on req_valid. Every accepted request
//   produces exactly one rsp_valid pulse (one cycle), in acceptance order;
//   there is no response back-pressure. rsp_rdata/rsp_err are meaningful only
//   while rsp_valid = 1.
//
//   req_valid  master->slave  request present
//   req_ready  slave->master  request can be accepted this cycle
//   req_we     master->slave  1 = store, 0 = load
//   req_mode   master->slave  001 W, 010 H, 011 B, 100 HU, 101 BU
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data, LSB-aligned
//   rsp_valid  slave->master  response pulse
//   rsp_rdata  slave->master  load data (extended), 0 for stores/errors
//   rsp_err    slave->master  request was illegal
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_mode, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_mode, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Pipelined data memory for the RV32 core. Word-organised RAM with
//   little-endian byte lanes, automatic two-beat split of word-crossing
//   accesses, range/mode error reporting, an RD_LAT-deep in-order response
//   pipeline and a memory-mapped synchronised trigger at MMIO_ADDR.
//
//   Parameters
//     ADDR_WIDTH   byte-address bits (RAM = 2**ADDR_WIDTH bytes)
//     RD_LAT       response stages after the final access beat, 1..3
//     MMIO_ADDR    address whose word returns the synchronised trigger
//     INIT_FILE    byte image name for the preload flow (no preload here)
//     INIT_OFFSET  byte offset of that image
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     trigger    asynchronous external trigger input
//     bus        request/response bundle (slave side)
//     dbg_state  1 while the FSM is in its second (SPLIT) beat
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int          ADDR_WIDTH  = 17,
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] MMIO_ADDR   = 32'h100,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] INIT_OFFSET = 32'h10000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trigger,
    data_mem_ctrl_if.slave bus,
    output logic          dbg_state
);

    localparam int WI     = ADDR_WIDTH - 2;
    localparam int NWORDS = 1 << WI;

    typedef enum logic [0:0] {S_IDLE, S_SPLIT} state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [2:0]    mode;
    logic [1:0]    off;
    logic [WI-1:0] idx;
    logic          is_w, is_h, mode_bad, misal, is_mmio, range_bad, wrap_bad;
    logic          req_err, do_split, accept;
    logic [3:0]    be4;
    logic [5:0]    wshamt;
    logic [63:0]   wsh;
    logic [7:0]    be8;

    assign mode      = bus.req_mode;
    assign off       = bus.req_addr[1:0];
    assign idx       = bus.req_addr[ADDR_WIDTH-1:2];
    assign is_w      = (mode == 3'b001);
    assign is_h      = (mode == 3'b010) || (mode == 3'b100);
    assign mode_bad  = (mode == 3'b000) || (mode == 3'b110) || (mode == 3'b111);
    assign misal     = is_w ? (off != 2'd0) : (is_h ? (off == 2'd3) : 1'b0);
    assign is_mmio   = (bus.req_addr[31:2] == MMIO_ADDR[31:2]);
    assign range_bad = |bus.req_addr[31:ADDR_WIDTH];
    // No wrap-around: a crossing access starting in the last word has nowhere to go.
    assign wrap_bad  = misal && (&idx);
    assign req_err   = mode_bad || (!is_mmio && (range_bad || wrap_bad));
    assign do_split  = !req_err && !is_mmio && misal;
    assign accept    = bus.req_valid && bus.req_ready;

    assign be4    = is_w ? 4'b1111 : (is_h ? 4'b0011 : 4'b0001);
    assign wshamt = {off, 3'b000};
    // Store data and lane enables laid across two words; upper half is beat 2.
    assign wsh    = {32'b0, bus.req_wdata} << wshamt;
    assign be8    = {4'b0000, be4} << off;

    assign bus.req_ready = rst_n && (state == S_IDLE);
    assign dbg_state     = (state == S_SPLIT);

    // ------------------------------------------------------------------
    // Split-beat holding registers and stage-1 response metadata
    // ------------------------------------------------------------------
    logic [WI-1:0] sp_idx;
    logic          sp_we, sp_load;
    logic [31:0]   sp_data;
    logic [3:0]    sp_be;
    logic [2:0]    sp_mode;
    logic [1:0]    sp_off;

    logic          s1_valid, s1_err, s1_load, s1_mmio, s1_split, s1_trig;
    logic [2:0]    s1_mode;
    logic [1:0]    s1_off;

    logic [1:0]    trig_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            trig_ff  <= 2'b00;
            sp_idx   <= '0;
            sp_we    <= 1'b0;
            sp_load  <= 1'b0;
            sp_data  <= '0;
            sp_be    <= '0;
            sp_mode  <= '0;
            sp_off   <= '0;
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_load  <= 1'b0;
            s1_mmio  <= 1'b0;
            s1_split <= 1'b0;
            s1_trig  <= 1'b0;
            s1_mode  <= '0;
            s1_off   <= '0;
        end else begin
            trig_ff  <= {trig_ff[0], trigger};
            s1_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (do_split) begin
                            state   <= S_SPLIT;
                            sp_idx  <= idx + 1'b1;
                            sp_we   <= bus.req_we;
                            sp_load <= !bus.req_we;
                            sp_data <= wsh[63:32];
                            sp_be   <= be8[7:4];
                            sp_mode <= mode;
                            sp_off  <= off;
                        end else begin
                            s1_valid <= 1'b1;
                            s1_err   <= req_err;
                            s1_load  <= !bus.req_we;
                            s1_mmio  <= is_mmio;
                            s1_split <= 1'b0;
                            s1_trig  <= trig_ff[1];
                            s1_mode  <= mode;
                            s1_off   <= off;
                        end
                    end
                end
                S_SPLIT: begin
                    state    <= S_IDLE;
                    s1_valid <= 1'b1;
                    s1_err   <= 1'b0;
                    s1_load  <= sp_load;
                    s1_mmio  <= 1'b0;
                    s1_split <= 1'b1;
                    s1_mode  <= sp_mode;
                    s1_off   <= sp_off;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM: byte-lane writes, registered read. A store and a load never
    // share a beat, so a load accepted after a store sees the new data.
    // ------------------------------------------------------------------
    logic [31:0]   mem [NWORDS];
    logic          mem_we;
    logic [WI-1:0] mem_widx, rd_idx;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   rd_word, lo_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = idx;
        mem_wdata = wsh[31:0];
        mem_be    = be8[3:0];
        rd_idx    = idx;
        if (state == S_SPLIT) begin
            mem_we    = sp_we;
            mem_widx  = sp_idx;
            mem_wdata = sp_data;
            mem_be    = sp_be;
            rd_idx    = sp_idx;
        end else begin
            mem_we = accept && bus.req_we && !req_err && !is_mmio;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we && mem_be[k]) begin
                mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
        rd_word <= mem[rd_idx];
        // During SPLIT rd_word still holds the beat-1 word; park it.
        if (state == S_SPLIT) begin
            lo_q <= rd_word;
        end
    end

    // ------------------------------------------------------------------
    // Stage-1 result: merge, lane shift, extension
    // ------------------------------------------------------------------
    logic [63:0] s1_data64, s1_sh;
    logic [31:0] s1_v, s1_ext, s1_rdata;
    logic [33:0] s1_rsp, rsp;

    always_comb begin
        s1_data64 = s1_split ? {rd_word, lo_q} : {32'b0, rd_word};
        s1_sh     = s1_data64 >> {s1_off, 3'b000};
        s1_v      = s1_sh[31:0];
        case (s1_mode)
            3'b001:  s1_ext = s1_v;
            3'b010:  s1_ext = {{16{s1_v[15]}}, s1_v[15:0]};
            3'b100:  s1_ext = {16'b0, s1_v[15:0]};
            3'b011:  s1_ext = {{24{s1_v[7]}}, s1_v[7:0]};
            default: s1_ext = {24'b0, s1_v[7:0]};
        endcase
        if (!s1_valid || s1_err || !s1_load) begin
            s1_rdata = 32'b0;
        end else if (s1_mmio) begin
            s1_rdata = {31'b0, s1_trig};
        end else begin
            s1_rdata = s1_ext;
        end
        s1_rsp = {s1_valid, s1_valid && s1_err, s1_rdata};
    end

    // Remaining RD_LAT-1 stages are a plain shift register.
    generate
        if (RD_LAT <= 1) begin : g_lat1
            assign rsp = s1_rsp;
        end else begin : g_latn
            logic [33:0] pipe_q [RD_LAT-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < RD_LAT - 1; k++) pipe_q[k] <= '0;
                end else begin
                    pipe_q[0] <= s1_rsp;
                    for (int k = 1; k < RD_LAT - 1; k++) pipe_q[k] <= pipe_q[k-1];
                end
            end
            assign rsp = pipe_q[RD_LAT-2];
        end
    endgenerate

    assign bus.rsp_valid = rsp[33];
    assign bus.rsp_err   = rsp[32];
    assign bus.rsp_rdata = rsp[31:0];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Two controllers (RD_LAT = 1 and RD_LAT = 3) receive identical requests.
//   A byte-level reference model predicts each response; predictions are
//   queued with their due cycle and a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int          AW        = 17;
    localparam int          RAM_BYTES = 1 << AW;
    localparam logic [31:0] MMIO      = 32'h100;
    localparam int          LAT_A     = 1;
    localparam int          LAT_B     = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trigger = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl_if bus_a ();
    data_mem_ctrl_if bus_b ();
    logic dbg_a, dbg_b;

    data_mem_ctrl #(.ADDR_WIDTH(AW), .RD_LAT(LAT_A), .MMIO_ADDR(MMIO)) dut_a (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .bus(bus_a), .dbg_state(dbg_a)
    );
    data_mem_ctrl #(.ADDR_WIDTH(AW), .RD_LAT(LAT_B), .MMIO_ADDR(MMIO)) dut_b (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .bus(bus_b), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [64:0] exp_a[$];   // {due_cycle[31:0], err, rdata[31:0]}
    logic [64:0] exp_b[$];
    logic [7:0]  ref_mem [int];
    bit          trig_level = 1'b0;

    // ---------------- reference model ----------------
    function automatic int msize(input logic [2:0] m);
        case (m)
            3'b001:          return 4;
            3'b010, 3'b100:  return 2;
            3'b011, 3'b101:  return 1;
            default:         return 0;
        endcase
    endfunction

    function automatic void model(input bit we, input logic [2:0] m, input logic [31:0] a,
                                  input logic [31:0] d, output bit err,
                                  output logic [31:0] data, output bit split);
        int sz;
        logic [32:0] last;
        sz    = msize(m);
        err   = 1'b0;
        data  = 32'b0;
        split = 1'b0;
        last  = {1'b0, a} + 33'(sz);
        if (sz == 0) begin
            err = 1'b1;
        end else if ((a >> 2) == (MMIO >> 2)) begin
            if (!we) data = {31'b0, trig_level};
        end else if (last > 33'(RAM_BYTES)) begin
            err = 1'b1;
        end else begin
            split = (int'(a % 4) + sz) > 4;
            if (we) begin
                for (int k = 0; k < sz; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
            end else begin
                for (int k = 0; k < sz; k++) data = data | (32'(ref_mem[int'(a) + k]) << (8 * k));
                if (m == 3'b010 && data[15]) data = data | 32'hFFFF_0000;
                if (m == 3'b011 && data[7])  data = data | 32'hFFFF_FF00;
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit v, input bit we, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] d);
        bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_mode = m;
        bus_a.req_addr  = a; bus_a.req_wdata = d;
        bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_mode = m;
        bus_b.req_addr  = a; bus_b.req_wdata = d;
    endtask

    task automatic send_core(input bit we, input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] d, input bit chk, input bit ovr,
                             input logic [31:0] kd, input bit ke);
        bit err, sp;
        logic [31:0] data;
        int n, acc;
        err = 1'b0; sp = 1'b0; data = 32'b0;
        if (chk) model(we, m, a, d, err, data, sp);
        if (ovr) begin data = kd; err = ke; end
        @(negedge clk);
        drive(1'b1, we, m, a, d);
        n = 0;
        while (!(bus_a.req_ready && bus_b.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL ready_timeout addr=%h got ready=%b/%b required 1", a,
                     bus_a.req_ready, bus_b.req_ready);
            drive(1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
            return;
        end
        acc = cyc;
        if (chk) begin
            exp_a.push_back({32'(acc + LAT_A + int'(sp)), err, data});
            exp_b.push_back({32'(acc + LAT_B + int'(sp)), err, data});
        end
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
    endtask

    task automatic send(input bit we, input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
        send_core(we, m, a, d, 1'b1, 1'b0, 32'b0, 1'b0);
    endtask

    task automatic send_k(input bit we, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] kd, input bit ke);
        send_core(we, m, a, d, 1'b1, 1'b1, kd, ke);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h required=%h", nm, got, want);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- monitor ----------------
    function automatic int qsize(input bit b);
        return b ? exp_b.size() : exp_a.size();
    endfunction

    function automatic logic [64:0] qpop(input bit b);
        if (b) return exp_b.pop_front();
        return exp_a.pop_front();
    endfunction

    function automatic logic [64:0] qfront(input bit b);
        if (b) return exp_b[0];
        return exp_a[0];
    endfunction

    task automatic mon_port(input bit b, input logic v, input logic [31:0] d, input logic e);
        logic [64:0] x;
        if (qsize(b) > 0) begin
            x = qfront(b);
            if (x[64:33] < 32'(cyc)) begin
                x = qpop(b);
                total++; bad++;
                $display("FAIL rsp_missing_%s due=%0d now=%0d required data=%h err=%b",
                         b ? "b" : "a", x[64:33], cyc, x[31:0], x[32]);
            end
        end
        if (v === 1'b1) begin
            total++;
            if (qsize(b) == 0) begin
                bad++;
                $display("FAIL rsp_unexpected_%s cyc=%0d got data=%h err=%b required no response",
                         b ? "b" : "a", cyc, d, e);
            end else begin
                x = qpop(b);
                if (x[64:33] != 32'(cyc) || e !== x[32] || d !== x[31:0]) begin
                    bad++;
                    $display("FAIL rsp_%s got cyc=%0d err=%b data=%h required cyc=%0d err=%b data=%h",
                             b ? "b" : "a", cyc, e, d, x[64:33], x[32], x[31:0]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_port(1'b0, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err);
            mon_port(1'b1, bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.rsp_err);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        logic [2:0]  m;
        logic [31:0] a;
        bit we;
        logic [2:0] bad_modes [3];
        bad_modes[0] = 3'b000; bad_modes[1] = 3'b110; bad_modes[2] = 3'b111;

        drive(1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        repeat (3) @(negedge clk);
        chk("reset_ready_a", 32'(bus_a.req_ready), 32'd0);
        chk("reset_rsp_a", {bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata[29:0]}, 32'd0);
        chk("reset_rsp_b", {bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_rdata[29:0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {30'b0, bus_a.req_ready, bus_b.req_ready}, 32'd3);

        // Prefill the working window so every later load has known bytes.
        for (int w = 32'h200; w < 32'h300; w += 4) send(1'b1, 3'b001, 32'(w), $urandom);
        send(1'b1, 3'b001, 32'h300, 32'h1122_3344);
        send(1'b1, 3'b001, 32'h304, 32'h5566_7788);

        // Byte lanes and extension.
        send_k(1'b1, 3'b001, 32'h200, 32'hDEAD_BEEF, 32'h0, 1'b0);
        send_k(1'b0, 3'b001, 32'h200, 32'h0, 32'hDEAD_BEEF, 1'b0);
        send_k(1'b0, 3'b101, 32'h200, 32'h0, 32'h0000_00EF, 1'b0);
        send_k(1'b0, 3'b011, 32'h203, 32'h0, 32'hFFFF_FFDE, 1'b0);

        // Word-crossing halfword store: ready drops for exactly one cycle.
        send_k(1'b1, 3'b010, 32'h1FF, 32'h0000_8001, 32'h0, 1'b0);
        @(negedge clk);
        chk("split_ready_low", {30'b0, bus_a.req_ready, dbg_a}, 32'd1);
        @(negedge clk);
        chk("split_ready_back", {30'b0, bus_b.req_ready, dbg_b}, 32'd2);
        send_k(1'b0, 3'b010, 32'h1FF, 32'h0, 32'hFFFF_8001, 1'b0);
        send_k(1'b0, 3'b100, 32'h1FF, 32'h0, 32'h0000_8001, 1'b0);

        // MMIO trigger.
        trigger = 1'b1; trig_level = 1'b1;
        repeat (3) @(negedge clk);
        send_k(1'b0, 3'b001, 32'h100, 32'h0, 32'h0000_0001, 1'b0);
        send_k(1'b1, 3'b001, 32'h100, 32'h55, 32'h0, 1'b0);
        send_k(1'b0, 3'b001, 32'h100, 32'h0, 32'h0000_0001, 1'b0);
        send(1'b0, 3'b011, 32'h101, 32'h0);
        drain();
        trigger = 1'b0; trig_level = 1'b0;
        repeat (3) @(negedge clk);
        send(1'b0, 3'b010, 32'h102, 32'h0);

        // Errors write nothing.
        send_k(1'b1, 3'b111, 32'h204, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send_k(1'b1, 3'b001, 32'h20000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send(1'b0, 3'b001, 32'h204, 32'h0);
        send_k(1'b0, 3'b001, 32'h1FFFE, 32'h0, 32'h0, 1'b1);
        send_k(1'b0, 3'b000, 32'h208, 32'h0, 32'h0, 1'b1);

        // Back-to-back aligned loads.
        drain();
        for (int k = 0; k < 4; k++) send(1'b0, 3'b001, 32'h208 + 32'(4 * k), 32'h0);

        // Reset in the middle of a split store.
        drain();
        send_core(1'b1, 3'b001, 32'h301, 32'hA1B2_C3D4, 1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        ref_mem[32'h301] = 8'hD4;
        ref_mem[32'h302] = 8'hC3;
        ref_mem[32'h303] = 8'hB2;
        @(negedge clk);
        chk("abort_ready", {30'b0, bus_a.req_ready, bus_b.req_ready}, 32'd0);
        chk("abort_rsp_a", {bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata[29:0]}, 32'd0);
        chk("abort_rsp_b", {bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_rdata[29:0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(1'b0, 3'b001, 32'h300, 32'h0);
        send(1'b0, 3'b101, 32'h304, 32'h0);
        send(1'b0, 3'b001, 32'h304, 32'h0);

        // Randomised mix.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            we = 1'($urandom_range(0, 1));
            m  = 3'($urandom_range(1, 5));
            if ($urandom_range(0, 99) < 8) m = bad_modes[$urandom_range(0, 2)];
            if (r < 70)      a = 32'h200 + 32'($urandom_range(0, 32'hFB));
            else if (r < 80) a = MMIO + 32'($urandom_range(0, 3));
            else if (r < 88) a = 32'h20000 + 32'($urandom_range(0, 32'hFFFF));
            else if (r < 90) a = 32'hFFFF_0000 + 32'($urandom_range(0, 255));
            else begin
                a = 32'h1FFFD + 32'($urandom_range(0, 2));
                if (msize(m) != 0) m = 3'b001;
            end
            send(we, m, a, $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        drain();
        while (exp_a.size() > 0) begin
            void'(exp_a.pop_front());
            total++; bad++;
            $display("FAIL rsp_leftover_a got none required one response");
        end
        while (exp_b.size() > 0) begin
            void'(exp_b.pop_front());
            total++; bad++;
            $display("FAIL rsp_leftover_b got none required one response");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
